fetch_unit: RTL and testbench

Instruction-issue side of the 9-bit processor: owns the program counter, presents each instruction word to the control decoder, and advances or redirects the PC from the decoder's branch result. It sits between instruction memory, which has combinational read, and the control decoder. It also runs the top-level start/done handshake, detects the halt instruction, guards against PC run-away, and counts execution cycles.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-issue stage of the 9-bit processor. Owns the program counter,
// presents the instruction at pc to the control decoder, and advances or
// redirects pc from the decoder's branch result. Also runs the start/done
// handshake, stops on the halt instruction, flags PC run-away and counts
// RUN cycles.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-low
//   start       in   begin execution at pc 0 (honoured in IDLE and DONE only)
//   imem_data   in   instruction memory read data for address pc
//   branch      in   decoder Branch output for the current instruction
//   cond        in   branch condition from the ALU (1 = take)
//   target      in   branch target, valid when branch=1
//   pc          out  program counter, drives instruction memory address
//   instr       out  instruction to the decoder, 0 outside RUN
//   instr_valid out  high in RUN only
//   done        out  execution finished, held until the next start
//   fault       out  run-away detected, meaningful while done=1
//   cycle_cnt   out  RUN cycles of the current or last program (saturating)

module fetch_unit #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter logic [INSTR_W-1:0] HALT_CODE = 9'h1F0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch,
  input  logic               cond,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               done,
  output logic               fault,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  state_t             state_n;
  logic [PC_W-1:0]    pc_n;
  logic               fault_n;
  logic [CNT_W-1:0]   cnt_n;

  // State register. Reset is synchronous and wins over start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      fault     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      fault     <= fault_n;
      cycle_cnt <= cnt_n;
    end
  end

  // Next-state logic. In RUN the halt check comes first so a halt word that
  // happens to be decoded as a branch still stops execution; a taken branch
  // at the last address is legal, so run-away is only flagged when pc would
  // have to step past the top of memory.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = fault;
    cnt_n   = cycle_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = '0;
          cnt_n   = '0;
          fault_n = 1'b0;
        end
      end
      RUN: begin
        if (cycle_cnt != CNT_MAX) begin
          cnt_n = cycle_cnt + 1'b1;
        end
        if (imem_data == HALT_CODE) begin
          state_n = DONE;
        end else if (branch && cond) begin
          pc_n = target;
        end else if (pc == PC_MAX) begin
          state_n = DONE;
          fault_n = 1'b1;
        end else begin
          pc_n = pc + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign instr_valid = (state == RUN);
  assign done        = (state == DONE);
  assign instr       = instr_valid ? imem_data : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Drives fetch_unit (PC_W=4, CNT_W=5 so run-away and counter saturation are
// reachable quickly) from a small instruction/branch memory model. Expected
// pc values are queued per program and compared as each RUN cycle is issued.

module tb_fetch_unit;

  localparam int                PC_W      = 4;
  localparam int                INSTR_W   = 9;
  localparam logic [INSTR_W-1:0] HALT_CODE = 9'h1F0;
  localparam int                CNT_W     = 5;
  localparam int                DEPTH     = 1 << PC_W;

  logic               clk;
  logic               reset;
  logic               start;
  logic [INSTR_W-1:0] imem_data;
  logic               branch;
  logic               cond;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               done;
  logic               fault;
  logic [CNT_W-1:0]   cycle_cnt;

  logic [INSTR_W-1:0] imem  [DEPTH];
  logic               isBr  [DEPTH];
  logic [PC_W-1:0]    brTgt [DEPTH];

  logic [PC_W-1:0]    expQ[$];

  int checksTotal;
  int checksPassed;

  fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .HALT_CODE(HALT_CODE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_data  (imem_data),
    .branch     (branch),
    .cond       (cond),
    .target     (target),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .done       (done),
    .fault      (fault),
    .cycle_cnt  (cycle_cnt)
  );

  // Combinational instruction memory and branch lookup, both addressed by pc.
  assign imem_data = imem[pc];
  assign branch    = isBr[pc];
  assign target    = brTgt[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstVal, input logic startVal, input logic condVal);
    reset = rstVal;
    start = startVal;
    cond  = condVal;
  endtask

  // Fill memory with distinct non-halt, non-branch words.
  task automatic clearMem();
    for (int i = 0; i < DEPTH; i++) begin
      imem[i]  = INSTR_W'(i * 3 + 1);
      isBr[i]  = 1'b0;
      brTgt[i] = '0;
    end
  endtask

  task automatic pushRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      expQ.push_back(PC_W'(i));
    end
  endtask

  task automatic startProgram();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  // Walks RUN cycles, comparing pc/instr against the queue. cond is dropped
  // once the RUN cycle index reaches condOffAt.
  task automatic runProgram(input int maxCycles, input int condOffAt);
    logic [PC_W-1:0] e;
    int idx;
    idx = 0;
    while (instr_valid && idx < maxCycles) begin
      if (idx >= condOffAt) cond = 1'b0;
      if (expQ.size() == 0) begin
        checkOutput("pc_extra", 32'(pc), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("pc_seq", 32'(pc), 32'(e));
        checkOutput("instr", 32'(instr), 32'(imem[e]));
      end
      stepCycle();
      idx++;
    end
    checkOutput("run_timeout", 32'(instr_valid), 32'd0);
    checkOutput("pc_missing", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  // Post-program checks, then confirm DONE holds its outputs.
  task automatic finishCheck(input int expPc, input int expCnt, input logic expFault);
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("done_instr", 32'(instr), 32'd0);
    checkOutput("done_pc", 32'(pc), 32'(expPc));
    checkOutput("cycle_cnt", 32'(cycle_cnt), 32'(expCnt));
    checkOutput("fault", 32'(fault), 32'(expFault));
    stepCycle();
    stepCycle();
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_pc", 32'(pc), 32'(expPc));
    checkOutput("hold_cnt", 32'(cycle_cnt), 32'(expCnt));
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    clearMem();
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Reset held with start high.
    stepCycle();
    stepCycle();
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("idle_pc", 32'(pc), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_valid", 32'(instr_valid), 32'd0);

    // Straight line: 0..3 then halt at 4.
    $display("[TB] straight line");
    clearMem();
    imem[4] = HALT_CODE;
    pushRange(0, 4);
    startProgram();
    runProgram(40, 1000);
    finishCheck(4, 5, 1'b0);

    // Taken branch at 2 -> 7; halt at 7 also decodes as a taken branch and
    // must still halt.
    $display("[TB] branch taken");
    clearMem();
    isBr[2]  = 1'b1;
    brTgt[2] = 4'd7;
    imem[7]  = HALT_CODE;
    isBr[7]  = 1'b1;
    brTgt[7] = 4'd0;
    cond     = 1'b1;
    expQ.push_back(4'd0);
    expQ.push_back(4'd1);
    expQ.push_back(4'd2);
    expQ.push_back(4'd7);
    startProgram();
    runProgram(40, 1000);
    finishCheck(7, 4, 1'b0);

    // Same program, branch not taken.
    $display("[TB] branch not taken");
    cond = 1'b0;
    pushRange(0, 7);
    startProgram();
    runProgram(40, 1000);
    finishCheck(7, 8, 1'b0);

    // Self-loop at 5 for 10 cycles, then fall through to halt at 6.
    $display("[TB] self loop");
    clearMem();
    isBr[5]  = 1'b1;
    brTgt[5] = 4'd5;
    imem[6]  = HALT_CODE;
    cond     = 1'b1;
    pushRange(0, 4);
    for (int i = 0; i < 11; i++) expQ.push_back(4'd5);
    expQ.push_back(4'd6);
    startProgram();
    runProgram(60, 15);
    finishCheck(6, 17, 1'b0);

    // Long self-loop at 0 saturates the counter at 31.
    $display("[TB] counter saturation");
    clearMem();
    isBr[0]  = 1'b1;
    brTgt[0] = 4'd0;
    imem[1]  = HALT_CODE;
    cond     = 1'b1;
    for (int i = 0; i < 41; i++) expQ.push_back(4'd0);
    expQ.push_back(4'd1);
    startProgram();
    runProgram(100, 40);
    finishCheck(1, 31, 1'b0);

    // Run-away: no halt anywhere.
    $display("[TB] run-away");
    clearMem();
    cond = 1'b0;
    pushRange(0, 15);
    startProgram();
    runProgram(60, 1000);
    finishCheck(15, 16, 1'b1);

    // Restart clears fault; start during RUN is ignored; reset mid-run.
    $display("[TB] restart and mid-run reset");
    startProgram();
    checkOutput("re_fault", 32'(fault), 32'd0);
    checkOutput("re_done", 32'(done), 32'd0);
    checkOutput("re_pc", 32'(pc), 32'd0);
    checkOutput("re_cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("re_valid", 32'(instr_valid), 32'd1);
    stepCycle();
    checkOutput("run_pc1", 32'(pc), 32'd1);
    start = 1'b1;
    stepCycle();
    checkOutput("ign_start_pc", 32'(pc), 32'd2);
    checkOutput("ign_start_cnt", 32'(cycle_cnt), 32'd2);
    stepCycle();
    checkOutput("run_pc3", 32'(pc), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("mid_rst_pc", 32'(pc), 32'd0);
    checkOutput("mid_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("post_rst_pc", 32'(pc), 32'd0);
    checkOutput("post_rst_valid", 32'(instr_valid), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
